add64_result_fifo: RTL and testbench

Downstream consumer of the pipelined 64-bit adder. It delay-matches a caller-supplied operand valid to the adder's pipeline latency, captures each 65-bit `sum` when that valid emerges, and buffers results in a small first-word-fall-through FIFO with a ready/valid output. Results that arrive while the FIFO is full are dropped, and a sticky overflow flag records the drop.

---
 rtl/add64_result_fifo.sv | 127 ++++++++++++
 tb/tb_add64_result_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add64_result_fifo.sv
// ============================================================================
// Module   : add64_result_fifo
// Purpose  : Delay-matches the adder's operand valid, captures each sum into a
//            first-word-fall-through FIFO, drops (and flags) results on full.
//            Define ADD64_RB_DROPCNT_EN to add a saturating 16-bit drop_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add64_result_fifo #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8,
    parameter int SUM_W   = 65
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_vld,
    input  logic [SUM_W-1:0]           sum,
    output logic                       out_vld,
    output logic [SUM_W-1:0]           out_sum,
    input  logic                       out_rdy,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       ovf_clr,
    output logic                       overflow
`ifdef ADD64_RB_DROPCNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int                c_ptr_w      = $clog2(DEPTH);
    localparam int                c_cnt_w      = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(DEPTH);

    logic [LATENCY-1:0]  r_vld_sr;
    logic [SUM_W-1:0]    r_mem [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_overflow;

    logic w_d_vld;
    logic w_full;
    logic w_empty;
    logic w_rd;
    logic w_wr;
    logic w_drop;

    generate
        if (LATENCY == 1) begin : g_sr_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld_sr <= '0;
                else        r_vld_sr <= in_vld;
            end
        end else begin : g_sr_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld_sr <= '0;
                else        r_vld_sr <= {r_vld_sr[LATENCY-2:0], in_vld};
            end
        end
    endgenerate

    // Status flags come only from the registered count, so out_rdy never
    // reaches full combinationally.
    assign w_d_vld = r_vld_sr[LATENCY-1];
    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);
    assign w_rd    = !w_empty & out_rdy;
    assign w_wr    = w_d_vld & (!w_full | w_rd);
    assign w_drop  = w_d_vld & w_full & !w_rd;

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_overflow <= 1'b0;
        else if (w_drop)  r_overflow <= 1'b1;
        else if (ovf_clr) r_overflow <= 1'b0;
    end

`ifdef ADD64_RB_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (ovf_clr) begin
            r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign out_vld  = !w_empty;
    assign out_sum  = r_mem[r_rd_ptr];
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_add64_result_fifo.sv
// ============================================================================
// Module   : tb_add64_result_fifo
// Purpose  : Self-checking bench for add64_result_fifo with a queue-based
//            reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add64_result_fifo;

    localparam int LATENCY = 4;
    localparam int DEPTH   = 8;
    localparam int SUM_W   = 65;

    logic              clk;
    logic              rst_n;
    logic              in_vld;
    logic [63:0]       x;
    logic [63:0]       y;
    logic [SUM_W-1:0]  sum;
    logic              out_vld;
    logic [SUM_W-1:0]  out_sum;
    logic              out_rdy;
    logic              full;
    logic              empty;
    logic [$clog2(DEPTH):0] count;
    logic              ovf_clr;
    logic              overflow;
`ifdef ADD64_RB_DROPCNT_EN
    logic [15:0]       drop_cnt;
`endif

    add64_result_fifo #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .SUM_W   (SUM_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .sum      (sum),
        .out_vld  (out_vld),
        .out_sum  (out_sum),
        .out_rdy  (out_rdy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .ovf_clr  (ovf_clr),
        .overflow (overflow)
`ifdef ADD64_RB_DROPCNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the pipelined adder feeding the FIFO.
    logic [SUM_W-1:0] adder_pipe [LATENCY];
    always @(posedge clk) begin
        adder_pipe[0] <= {1'b0, x} + {1'b0, y};
        for (int i = 1; i < LATENCY; i++) adder_pipe[i] <= adder_pipe[i-1];
    end
    assign sum = adder_pipe[LATENCY-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [SUM_W-1:0] act, input logic [SUM_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: results are scheduled to land LATENCY edges after
    // their in_vld is sampled, and the FIFO is a plain queue.
    logic [SUM_W-1:0] mq [$];
    logic [SUM_W-1:0] arrive [int];
    logic [SUM_W-1:0] out_log [$];
    bit               log_en = 0;
    bit               m_ovf  = 0;
    int               m_drops = 0;
    int               tick = 0;

    always @(negedge clk) begin
        bit               d, rd, wr, drop;
        logic [SUM_W-1:0] v;
        tick++;
        if (!rst_n) begin
            chk("rst_out_vld", out_vld, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_count", count, 0);
            chk("rst_overflow", overflow, 0);
`ifdef ADD64_RB_DROPCNT_EN
            chk("rst_drop_cnt", drop_cnt, 0);
`endif
            mq.delete();
            arrive.delete();
            m_ovf   = 0;
            m_drops = 0;
        end else begin
            chk("out_vld", out_vld, mq.size() != 0);
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("count", count, mq.size());
            chk("overflow", overflow, m_ovf);
`ifdef ADD64_RB_DROPCNT_EN
            chk("drop_cnt", drop_cnt, m_drops);
`endif
            if (mq.size() != 0) chk("out_sum", out_sum, mq[0]);
            if (log_en && out_vld && out_rdy) out_log.push_back(out_sum);

            d = arrive.exists(tick);
            v = '0;
            if (d) begin
                v = arrive[tick];
                arrive.delete(tick);
            end
            if (in_vld) arrive[tick + LATENCY] = {1'b0, x} + {1'b0, y};
            rd   = (mq.size() != 0) && out_rdy;
            wr   = d && ((mq.size() < DEPTH) || rd);
            drop = d && !wr;
            if (rd) void'(mq.pop_front());
            if (wr) mq.push_back(v);
            if (ovf_clr) begin
                m_ovf   = drop;
                m_drops = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf = 1;
                if (m_drops < 65535) m_drops++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] b);
        in_vld = 1'b1;
        x      = a;
        y      = b;
    endtask

    initial begin
        int sent;
        int guard;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        x       = '0;
        y       = '0;
        out_rdy = 1'b0;
        ovf_clr = 1'b0;

        // Reset release, stream 20 results, drain.
        step();
        step();
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        log_en  = 1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i <= LATENCY + 2) chk("lat_out_vld", out_vld, i >= LATENCY + 2);
            push(i, i);
        end
        step();
        in_vld = 1'b0;
        repeat (LATENCY + 4) step();
        chk("stream_n", out_log.size(), 20);
        for (int i = 0; i < 20 && i < out_log.size(); i++) chk("stream_val", out_log[i], 2 * (i + 1));
        chk("stream_ovf", overflow, 0);
        log_en = 0;
        out_log.delete();

        // Fill and hold, then drop two more.
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(100 + i, i);
            step();
        end
        in_vld = 1'b0;
        repeat (LATENCY + 2) step();
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        chk("fill_head", out_sum, 100);
        push(200, 0);
        step();
        push(201, 0);
        step();
        in_vld = 1'b0;
        repeat (LATENCY + 2) step();
        chk("drop_ovf", overflow, 1);
        chk("drop_head", out_sum, 100);
`ifdef ADD64_RB_DROPCNT_EN
        chk("drop_cnt2", drop_cnt, 2);
`endif

        // Clear in the same cycle as a drop: set wins.
        push(300, 0);
        step();
        in_vld = 1'b0;
        repeat (LATENCY - 1) step();
        ovf_clr = 1'b1;
        step();
        chk("clr_drop_ovf", overflow, 1);
`ifdef ADD64_RB_DROPCNT_EN
        chk("clr_drop_cnt", drop_cnt, 1);
`endif
        step();
        ovf_clr = 1'b0;
        chk("clr_alone_ovf", overflow, 0);
`ifdef ADD64_RB_DROPCNT_EN
        chk("clr_alone_cnt", drop_cnt, 0);
`endif

        // Full with simultaneous read and write.
        log_en = 1;
        push(500, 0);
        step();
        in_vld = 1'b0;
        repeat (LATENCY - 1) step();
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("rw_count", count, 8);
        chk("rw_ovf", overflow, 0);
        chk("rw_head", out_sum, 102);
        step();
        out_rdy = 1'b1;
        repeat (12) step();
        chk("rw_drain_n", out_log.size(), 9);
        for (int i = 0; i < 9 && i < out_log.size(); i++)
            chk("rw_drain_val", out_log[i], (i < 8) ? (100 + 2 * i) : 500);
        out_log.delete();

        // Wrap-around with random back-pressure; senders never overcommit.
        sent  = 0;
        guard = 0;
        while (sent < 3 * DEPTH && guard < 2000) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            if ((mq.size() + arrive.num() < DEPTH) && ($urandom_range(0, 1) == 1)) begin
                push(1000 + sent, 3 * sent);
                sent++;
            end else begin
                in_vld = 1'b0;
            end
            step();
            guard++;
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (LATENCY + DEPTH + 4) step();
        chk("wrap_n", out_log.size(), 3 * DEPTH);
        for (int i = 0; i < 3 * DEPTH && i < out_log.size(); i++)
            chk("wrap_val", out_log[i], 1000 + 4 * i);
        chk("wrap_ovf", overflow, 0);
        out_log.delete();

        // Reset mid-stream: 5 buffered, 3 in flight.
        out_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(40 + i, 0);
            step();
        end
        in_vld = 1'b0;
        step();
        chk("pre_rst_count", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_vld", out_vld, 0);
        chk("async_count", count, 0);
        chk("async_empty", empty, 1);
        step();
        step();
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        repeat (LATENCY + 8) step();
        chk("post_rst_stale", out_log.size(), 0);
        chk("post_rst_empty", empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
